// File: rtl/regfile_bypass_8x16_pkg.sv
// Shared datapath constants for the register file, ALU and pipeline latches.
package regfile_bypass_8x16_pkg;

    localparam int unsigned RF_WIDTH = 16;
    localparam int unsigned RF_NREG  = 8;
    localparam int unsigned RF_SEL_W = $clog2(RF_NREG);

    localparam logic [RF_WIDTH-1:0] RF_RESET_VAL = '0;

    typedef logic [RF_WIDTH-1:0] rf_word_t;
    typedef logic [RF_SEL_W-1:0] rf_sel_t;

endpackage

// File: rtl/regfile_bypass_8x16_reg_16b_en.sv
// Storage element: register with async active-high reset and synchronous enable.
module reg_16b_en
    import regfile_bypass_8x16_pkg::*;
#(
    parameter int unsigned WIDTH = RF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= WIDTH'(RF_RESET_VAL);
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_bypass_8x16.sv
// Register file with two combinational read ports, one write port and write-to-read bypass.
module regfile_bypass_8x16
    import regfile_bypass_8x16_pkg::*;
#(
    parameter int unsigned WIDTH = RF_WIDTH,
    parameter int unsigned NREG  = RF_NREG
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [$clog2(NREG)-1:0] read1RegSel,
    input  logic [$clog2(NREG)-1:0] read2RegSel,
    input  logic [$clog2(NREG)-1:0] writeRegSel,
    input  logic [WIDTH-1:0]        writeData,
    input  logic                    writeEn,
    output logic [WIDTH-1:0]        read1Data,
    output logic [WIDTH-1:0]        read2Data,
    output logic                    err
);

    localparam int unsigned SEL_W = $clog2(NREG);

    logic [NREG-1:0]  wr_en;
    logic [WIDTH-1:0] regs [NREG];
    logic             byp_ok;

    always_comb begin
        wr_en = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            wr_en[i] = writeEn && (writeRegSel == SEL_W'(i));
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_reg
        reg_16b_en #(.WIDTH(WIDTH)) u_reg (
            .clk (clk),
            .rst (rst),
            .en  (wr_en[g]),
            .d   (writeData),
            .q   (regs[g])
        );
    end

    // Bypass is suppressed under reset; the registers are already cleared
    // asynchronously, so the plain read path returns zero.
    assign byp_ok = writeEn && !rst;

    always_comb begin
        read1Data = regs[read1RegSel];
        read2Data = regs[read2RegSel];
        if (byp_ok && (writeRegSel == read1RegSel)) read1Data = writeData;
        if (byp_ok && (writeRegSel == read2RegSel)) read2Data = writeData;
    end

    always_comb begin
        err = $isunknown(writeEn) || $isunknown(read1RegSel) || $isunknown(read2RegSel);
        if (writeEn == 1'b1) begin
            err = err || $isunknown(writeRegSel) || $isunknown(writeData);
        end
    end

endmodule

// File: tb/tb_regfile_bypass_8x16.sv
// Self-checking bench for regfile_bypass_8x16: directed table, corner sequences, random vs. model.
module tb_regfile_bypass_8x16;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  r1s, r2s, ws;
    logic [15:0] wd;
    logic        we;
    logic [15:0] r1d, r2d;
    logic        err;

    int errors = 0;
    int checks = 0;

    logic [15:0] model [8];

    typedef struct {
        logic        we;
        logic [2:0]  ws;
        logic [15:0] wd;
        logic [2:0]  r1;
        logic [2:0]  r2;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    regfile_bypass_8x16 #(.WIDTH(16), .NREG(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .read1RegSel (r1s),
        .read2RegSel (r2s),
        .writeRegSel (ws),
        .writeData   (wd),
        .writeEn     (we),
        .read1Data   (r1d),
        .read2Data   (r2d),
        .err         (err)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    endtask

    // Apply one cycle of inputs, check reads against the model, then commit the write.
    task automatic step(input string name, input logic w_en, input logic [2:0] w_sel,
                        input logic [15:0] w_dat, input logic [2:0] a, input logic [2:0] b);
        logic [15:0] e1, e2;
        @(negedge clk);
        we = w_en; ws = w_sel; wd = w_dat; r1s = a; r2s = b;
        #1;
        e1 = (w_en && w_sel == a) ? w_dat : model[a];
        e2 = (w_en && w_sel == b) ? w_dat : model[b];
        chk({name, ".r1"}, r1d, e1);
        chk({name, ".r2"}, r2d, e2);
        chk({name, ".err"}, {15'd0, err}, 16'd0);
        if (w_en) model[w_sel] = w_dat;
    endtask

    initial begin
        logic        xv;
        logic [15:0] exp_err;

        vecs[0] = '{1'b1, 3'd3, 16'hA5A5, 3'd3, 3'd0, 16'hA5A5, 16'h0000};
        vecs[1] = '{1'b0, 3'd3, 16'h0000, 3'd3, 3'd3, 16'hA5A5, 16'hA5A5};
        vecs[2] = '{1'b1, 3'd2, 16'h00FF, 3'd2, 3'd3, 16'h00FF, 16'hA5A5};
        vecs[3] = '{1'b1, 3'd5, 16'h1234, 3'd5, 3'd2, 16'h1234, 16'h00FF};
        vecs[4] = '{1'b0, 3'd5, 16'hFFFF, 3'd5, 3'd5, 16'h1234, 16'h1234};
        vecs[5] = '{1'b1, 3'd0, 16'h7777, 3'd0, 3'd0, 16'h7777, 16'h7777};
        vecs[6] = '{1'b1, 3'd7, 16'h0001, 3'd7, 3'd0, 16'h0001, 16'h7777};
        vecs[7] = '{1'b0, 3'd4, 16'hDEAD, 3'd4, 3'd4, 16'h0000, 16'h0000};

        rst = 1'b1; we = 1'b0; ws = '0; wd = '0; r1s = '0; r2s = '0;
        clear_model();

        // Reset state on every index of both ports.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            r1s = 3'(i); r2s = 3'(7 - i); we = 1'b1; ws = 3'(i); wd = 16'hFFFF;
            #1;
            chk($sformatf("rst.r1[%0d]", i), r1d, 16'h0000);
            chk($sformatf("rst.r2[%0d]", 7 - i), r2d, 16'h0000);
            chk("rst.err", {15'd0, err}, 16'd0);
        end
        @(negedge clk);
        we = 1'b0; rst = 1'b0;

        // Directed table with constant expectations.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            we = vecs[i].we; ws = vecs[i].ws; wd = vecs[i].wd;
            r1s = vecs[i].r1; r2s = vecs[i].r2;
            #1;
            chk($sformatf("vec%0d.r1", i), r1d, vecs[i].e1);
            chk($sformatf("vec%0d.r2", i), r2d, vecs[i].e2);
        end
        model[3] = 16'hA5A5; model[2] = 16'h00FF; model[5] = 16'h1234;
        model[0] = 16'h7777; model[7] = 16'h0001;

        // Fill all registers, then read mirrored pairs.
        for (int i = 0; i < 8; i++) step("fill", 1'b1, 3'(i), 16'(16'h1111 * i), 3'(i), 3'(7 - i));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            we = 1'b0; r1s = 3'(i); r2s = 3'(7 - i);
            #1;
            chk($sformatf("pair.r1[%0d]", i), r1d, 16'(16'h1111 * i));
            chk($sformatf("pair.r2[%0d]", 7 - i), r2d, 16'(16'h1111 * (7 - i)));
        end
        step("we0_sel4", 1'b0, 3'd4, 16'h0BAD, 3'd4, 3'd3);
        step("r4_hold", 1'b0, 3'd0, 16'h0000, 3'd4, 3'd4);
        chk("r4_value", r1d, 16'h4444);

        // Reset asserted mid-cycle while a write to R1 is pending.
        step("r1_beef", 1'b1, 3'd1, 16'hBEEF, 3'd0, 3'd1);
        @(negedge clk);
        we = 1'b1; ws = 3'd1; wd = 16'h1234; r1s = 3'd1; r2s = 3'd3;
        #1;
        chk("pre_rst.r1", r1d, 16'h1234);
        chk("pre_rst.r2", r2d, 16'h3333);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst.r1", r1d, 16'h0000);
        chk("mid_rst.r2", r2d, 16'h0000);
        chk("mid_rst.err", {15'd0, err}, 16'd0);
        @(posedge clk);
        #1;
        chk("rst_edge.r1", r1d, 16'h0000);
        @(negedge clk);
        rst = 1'b0; we = 1'b0;
        clear_model();
        #1;
        chk("post_rst.r1", r1d, 16'h0000);
        step("post_rst_read", 1'b0, 3'd1, 16'h0000, 3'd1, 3'd3);
        step("rewrite_r1", 1'b1, 3'd1, 16'hCAFE, 3'd2, 3'd1);
        step("reread_r1", 1'b0, 3'd1, 16'h0000, 3'd1, 3'd1);

        // Unknown write enable raises err; a clean enable drops it again.
        @(negedge clk);
        xv = 1'bx;
        we = xv; r1s = 3'd0; r2s = 3'd1;
        exp_err = $isunknown(xv) ? 16'd1 : 16'd0;
        #1;
        chk("x_we.err", {15'd0, err}, exp_err);
        we = 1'b0;
        #1;
        chk("clean_we.err", {15'd0, err}, 16'd0);

        // Random traffic with occasional asynchronous reset pulses.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                @(negedge clk);
                we = 1'($urandom); ws = 3'($urandom); wd = 16'($urandom);
                r1s = 3'($urandom); r2s = 3'($urandom);
                #1 rst = 1'b1;
                #1;
                chk("rnd_rst.r1", r1d, 16'h0000);
                chk("rnd_rst.r2", r2d, 16'h0000);
                #1 rst = 1'b0;
                clear_model();
                we = 1'b0;
            end else begin
                step("rnd", 1'($urandom_range(0, 2) != 0), 3'($urandom), 16'($urandom),
                     3'($urandom), 3'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
